// File: rtl/operand_feeder.sv
// Operand FIFO plus burst sequencer feeding one row or column of a systolic PE array.
// A burst of len words is released after an optional SKEW delay; words leave in push order, untouched.
module operand_feeder #(
   parameter int DEPTH = 8,
   parameter int SKEW  = 0,
   parameter int LW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [31:0]   load_dat,
   input  logic          start,
   input  logic [LW-1:0] len,
   output logic          busy,
   output logic          done,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [31:0]   out_dat
);

   localparam int AW  = $clog2(DEPTH);
   localparam int SKW = ($clog2(SKEW + 1) > LW) ? $clog2(SKEW + 1) : LW;
   localparam bit HAS_SKEW = (SKEW > 0);
   localparam logic [SKW-1:0] SKEW_LOAD = HAS_SKEW ? SKW'(SKEW - 1) : {SKW{1'b0}};
   localparam logic [LW-1:0]  DEPTH_LW  = LW'(DEPTH);
   localparam logic [LW-1:0]  ONE_LW    = LW'(1'b1);
   localparam logic [LW-1:0]  ZERO_LW   = {LW{1'b0}};

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SKEW = 2'd1,
      ST_SEND = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   state_t          state_r;
   logic [31:0]     mem_r [DEPTH];
   logic [AW-1:0]   wr_ptr_r;
   logic [AW-1:0]   rd_ptr_r;
   logic [AW-1:0]   head_idx_s;
   logic [LW-1:0]   count_r;
   logic [LW-1:0]   count_nxt_s;
   logic [LW-1:0]   rem_r;
   logic [SKW-1:0]  skew_cnt_r;
   logic            load_ready_r;
   logic            out_valid_r;
   logic [31:0]     out_dat_r;
   logic            done_r;
   logic            busy_r;
   logic            push_s;
   logic            pop_s;
   logic            last_pop_s;
   logic            avail_s;

   // Handshake decode and next-cycle FIFO occupancy / head position.
   always_comb begin
      push_s      = load_valid && load_ready_r;
      pop_s       = out_valid_r && out_ready;
      count_nxt_s = count_r + LW'(push_s) - LW'(pop_s);
      head_idx_s  = rd_ptr_r + AW'(pop_s);
      last_pop_s  = pop_s && (rem_r == ONE_LW);
      // A word is left for the output register once the current pop is accounted for.
      avail_s     = (count_r > LW'(pop_s));
   end

   // Operand storage; holds data only, so it carries no reset.
   always_ff @(posedge clk) begin
      if (push_s) begin
         mem_r[wr_ptr_r] <= load_dat;
      end
   end

   // FIFO pointers, occupancy and the registered ready flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_r     <= {AW{1'b0}};
         rd_ptr_r     <= {AW{1'b0}};
         count_r      <= ZERO_LW;
         load_ready_r <= 1'b1;
      end else begin
         wr_ptr_r     <= wr_ptr_r + AW'(push_s);
         rd_ptr_r     <= head_idx_s;
         count_r      <= count_nxt_s;
         load_ready_r <= (count_nxt_s < DEPTH_LW);
      end
   end

   // Burst sequencer with registered out_valid/out_dat/done/busy.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= ST_IDLE;
         skew_cnt_r  <= {SKW{1'b0}};
         rem_r       <= ZERO_LW;
         out_valid_r <= 1'b0;
         out_dat_r   <= 32'h0;
         done_r      <= 1'b0;
         busy_r      <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               out_valid_r <= 1'b0;
               out_dat_r   <= 32'h0;
               done_r      <= 1'b0;
               if (start) begin
                  busy_r <= 1'b1;
                  rem_r  <= len;
                  if (len == ZERO_LW) begin
                     state_r <= ST_DONE;
                     done_r  <= 1'b1;
                  end else if (HAS_SKEW) begin
                     state_r    <= ST_SKEW;
                     skew_cnt_r <= SKEW_LOAD;
                  end else begin
                     state_r <= ST_SEND;
                  end
               end else begin
                  busy_r <= 1'b0;
               end
            end
            ST_SKEW: begin
               out_valid_r <= 1'b0;
               out_dat_r   <= 32'h0;
               if (skew_cnt_r == {SKW{1'b0}}) begin
                  state_r <= ST_SEND;
               end else begin
                  skew_cnt_r <= skew_cnt_r - SKW'(1'b1);
               end
            end
            ST_SEND: begin
               rem_r <= rem_r - LW'(pop_s);
               if (last_pop_s) begin
                  state_r     <= ST_DONE;
                  out_valid_r <= 1'b0;
                  out_dat_r   <= 32'h0;
                  done_r      <= 1'b1;
               end else if (avail_s) begin
                  // While stalled head_idx_s stays put, so out_dat holds its value.
                  out_valid_r <= 1'b1;
                  out_dat_r   <= mem_r[head_idx_s];
               end else begin
                  out_valid_r <= 1'b0;
                  out_dat_r   <= 32'h0;
               end
            end
            ST_DONE: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
               out_dat_r   <= 32'h0;
               done_r      <= 1'b0;
               busy_r      <= 1'b0;
            end
            default: begin
               state_r     <= ST_IDLE;
               out_valid_r <= 1'b0;
               out_dat_r   <= 32'h0;
               done_r      <= 1'b0;
               busy_r      <= 1'b0;
            end
         endcase
      end
   end

   assign load_ready = load_ready_r;
   assign out_valid  = out_valid_r;
   assign out_dat    = out_dat_r;
   assign done       = done_r;
   assign busy       = busy_r;

endmodule

// File: doc/operand_feeder.md
OPERAND_FEEDER -- requirements
Module: operand_feeder

Interface
REQ-001 Parameter DEPTH, default 8, sets the operand FIFO depth in FP32 words; it SHALL be a power of two and at least 2.
REQ-002 Parameter SKEW, default 0, sets the cycles inserted between start acceptance and the first send; this staggers systolic row/column entry.
REQ-003 Parameter LW, default $clog2(DEPTH)+1, SHALL set the width of len and of the internal counters.
REQ-004 Port clk, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, synchronous and active-high.
REQ-006 Port load_valid, input, 1 bit: the loader offers an operand.
REQ-007 Port load_ready, output, 1 bit: the FIFO can accept an operand.
REQ-008 Port load_dat, input, 32 bits: FP32 operand, single_float layout.
REQ-009 Port start, input, 1 bit: request to transmit len operands.
REQ-010 Port len, input, LW bits: operand count for the burst, sampled when start is accepted.
REQ-011 Port busy, output, 1 bit: high in every state except IDLE.
REQ-012 Port done, output, 1 bit: one-cycle pulse after the last operand handshakes.
REQ-013 Port out_valid, output, 1 bit: drives PE_if row_in_valid or col_in_valid.
REQ-014 Port out_ready, input, 1 bit: driven by PE_if row_in_ready or col_in_ready.
REQ-015 Port out_dat, output, 32 bits: drives PE_if row_in_dat or col_in_dat.

Function
REQ-016 The FIFO SHALL use wrapping read/write pointers plus a count register ranging 0..DEPTH; pointers SHALL wrap from DEPTH-1 to 0.
REQ-017 load_ready SHALL equal (count < DEPTH); a push SHALL occur when load_valid && load_ready.
REQ-018 A pop SHALL occur when out_valid && out_ready.
REQ-019 A simultaneous push and pop SHALL leave count unchanged; a push into a full FIFO is blocked by load_ready = 0.
REQ-020 The FSM SHALL have four states: IDLE, SKEW, SEND and DONE.
REQ-021 IDLE, start=1, len>0, SKEW>0: go to SKEW; load the skew counter with SKEW-1 and the remaining counter with len.
REQ-022 IDLE, start=1, len>0, SKEW=0: go directly to SEND.
REQ-023 IDLE, start=1, len=0: go to DONE, with no out_valid.
REQ-024 start SHALL be ignored outside IDLE.
REQ-025 SKEW: decrement the skew counter every cycle; when it is 0, go to SEND; out_valid=0 throughout.
REQ-026 SEND: out_valid = (count > 0), and out_dat = the FIFO head.
- Each pop SHALL decrement the remaining counter.
- The pop that takes remaining from 1 to 0 SHALL move the FSM to DONE.
REQ-027 If the FIFO empties during SEND, out_valid SHALL drop and SEND SHALL wait with no timeout; transmission resumes the cycle after the next push lands.
REQ-028 Once asserted, out_valid SHALL stay high and out_dat SHALL stay stable until the handshake completes.
REQ-029 out_dat SHALL be 32'h0 whenever out_valid=0.
REQ-030 DONE: done=1 for exactly one cycle, then go to IDLE; a start in that cycle SHALL be ignored.
REQ-031 Pushes SHALL be accepted in every state, so the next burst can be preloaded during SEND.
REQ-032 Operands SHALL leave in push order and unmodified; the block performs no arithmetic on the data.
REQ-033 Latency: with SKEW=s and the FIFO non-empty, the first out_valid SHALL appear s+1 cycles after the start-accept edge.

Reset
REQ-034 While rst=1 at a clock edge, all of the following SHALL hold on that edge:
- state = IDLE, and count, pointers and counters = 0.
- out_valid=0, out_dat=0, done=0, busy=0, load_ready=1.
REQ-035 A reset during SEND or SKEW SHALL abort the burst and discard all FIFO contents; the design SHALL need no recovery cycles after rst deasserts.

Verification
REQ-036 Basic burst. DEPTH=8, SKEW=0; push 3F800000, 40000000, 40400000; pulse start with len=3; out_ready=1 -> the three words appear on consecutive cycles, done pulses the cycle after the third, and busy then drops.
REQ-037 Skew. SKEW=3, FIFO preloaded with 4 words, start with len=4 -> out_valid first rises 4 cycles after the start edge.
REQ-038 Backpressure. Hold out_ready=0 for 5 cycles mid-burst -> out_valid stays 1, out_dat stays constant, and no word is lost or duplicated.
REQ-039 Full and empty. Push 9 words into DEPTH=8 with no start -> load_ready=0 after the 8th push and the 9th word is held off. Then start with len=10 -> out_valid drops after 8 words; 2 later pushes complete the burst and done pulses.
REQ-040 Edge cases:
- start with len=0 -> done pulses one cycle later, out_valid never rises.
- start asserted during SEND -> no effect.
REQ-041 Reset mid-burst. Assert rst during SEND with 5 words queued -> the next cycle shows count=0, out_valid=0, load_ready=1 and IDLE. A fresh burst of len=2 then behaves as in REQ-036.
